// File: rtl/time_set_ctrl.sv
// time_set_ctrl: BCD time-of-day keeper for the VGA clock.
// A seconds prescaler generates the 1 Hz tick while no field is being adjusted.
// Three adjust buttons are arbitrated (hours > minutes > seconds). One shared
// auto-repeat engine turns the granted button into increment pulses: the first
// pulse comes immediately, then the pulses speed up toward a floor spacing.
module time_set_ctrl #(
  parameter int CLK_HZ    = 31_500_000,
  parameter int REPEAT_HZ = 10,
  parameter int MAX_COUNT = 8,
  parameter int DEC_COUNT = 2,
  parameter int MIN_COUNT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       adj_hrs,
  input  logic       adj_min,
  input  logic       adj_sec,
  output logic [1:0] hrs_d,
  output logic [3:0] hrs_u,
  output logic [2:0] min_d,
  output logic [3:0] min_u,
  output logic [2:0] sec_d,
  output logic [3:0] sec_u,
  output logic       sec_tick,
  output logic       adj_active
);

  localparam int REP_PERIOD = (CLK_HZ / REPEAT_HZ < 1) ? 1 : CLK_HZ / REPEAT_HZ;
  localparam int SW = $clog2(CLK_HZ + 1);
  localparam int RW = $clog2(REP_PERIOD + 1);
  localparam int CW = $clog2(MAX_COUNT + MIN_COUNT + DEC_COUNT + 1);

  localparam logic [SW-1:0] SEC_LAST   = SW'(CLK_HZ - 1);
  localparam logic [RW-1:0] REP_LAST   = RW'(REP_PERIOD - 1);
  localparam logic [CW-1:0] COMP_INIT  = CW'(MAX_COUNT - 1);
  localparam logic [CW-1:0] COMP_FLOOR = CW'(MIN_COUNT + DEC_COUNT);
  localparam logic [CW-1:0] COMP_STEP  = CW'(DEC_COUNT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADJ_H = 2'd1,
    ADJ_M = 2'd2,
    ADJ_S = 2'd3
  } state_t;

  state_t        state;
  state_t        state_n;

  logic [SW-1:0] sec_pre;
  logic [RW-1:0] rep_pre;
  logic [CW-1:0] count;
  logic [CW-1:0] comp;

  logic          rep_en;
  logic          tick;
  logic          btn;
  logic          pulse;
  logic          release_edge;

  logic          sec_wrap;
  logic          min_wrap;
  logic          inc_s;
  logic          inc_m;
  logic          inc_h;

  logic [1:0]    hrs_d_n;
  logic [3:0]    hrs_u_n;
  logic [2:0]    min_d_n;
  logic [3:0]    min_u_n;
  logic [2:0]    sec_d_n;
  logic [3:0]    sec_u_n;

  // Arbiter next state: grant from IDLE by priority, drop back only on own release.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (adj_hrs)      state_n = ADJ_H;
        else if (adj_min) state_n = ADJ_M;
        else if (adj_sec) state_n = ADJ_S;
      end
      ADJ_H:   if (!adj_hrs) state_n = IDLE;
      ADJ_M:   if (!adj_min) state_n = IDLE;
      ADJ_S:   if (!adj_sec) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Button feeding the repeat engine: only the granted one, nothing while idle.
  always_comb begin
    btn = 1'b0;
    case (state)
      ADJ_H:   btn = adj_hrs;
      ADJ_M:   btn = adj_min;
      ADJ_S:   btn = adj_sec;
      default: btn = 1'b0;
    endcase
  end

  assign rep_en       = (rep_pre == REP_LAST);
  assign tick         = (state == IDLE) && (sec_pre == SEC_LAST);
  assign pulse        = rep_en && btn && (count == '0);
  assign release_edge = (state != IDLE) && (state_n == IDLE);

  // Which fields advance this cycle; tick carries, adjust pulses never carry.
  always_comb begin
    sec_wrap = (sec_d == 3'd5) && (sec_u == 4'd9);
    min_wrap = (min_d == 3'd5) && (min_u == 4'd9);
    inc_s    = tick || (pulse && (state == ADJ_S));
    inc_m    = (tick && sec_wrap) || (pulse && (state == ADJ_M));
    inc_h    = (tick && sec_wrap && min_wrap) || (pulse && (state == ADJ_H));
  end

  // Next BCD digit values; units wrap into tens, tens wrap at the field limit.
  always_comb begin
    hrs_d_n = hrs_d;
    hrs_u_n = hrs_u;
    min_d_n = min_d;
    min_u_n = min_u;
    sec_d_n = sec_d;
    sec_u_n = sec_u;

    if (inc_s) begin
      if (sec_u == 4'd9) begin
        sec_u_n = 4'd0;
        sec_d_n = (sec_d == 3'd5) ? 3'd0 : sec_d + 3'd1;
      end else begin
        sec_u_n = sec_u + 4'd1;
      end
    end

    if (inc_m) begin
      if (min_u == 4'd9) begin
        min_u_n = 4'd0;
        min_d_n = (min_d == 3'd5) ? 3'd0 : min_d + 3'd1;
      end else begin
        min_u_n = min_u + 4'd1;
      end
    end

    if (inc_h) begin
      if ((hrs_d == 2'd2) && (hrs_u == 4'd3)) begin
        hrs_d_n = 2'd0;
        hrs_u_n = 4'd0;
      end else if (hrs_u == 4'd9) begin
        hrs_u_n = 4'd0;
        hrs_d_n = hrs_d + 2'd1;
      end else begin
        hrs_u_n = hrs_u + 4'd1;
      end
    end
  end

  // Arbiter state register; adj_active mirrors the registered state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      adj_active <= 1'b0;
    end else begin
      state      <= state_n;
      adj_active <= (state_n != IDLE);
    end
  end

  // Seconds prescaler: frozen at 0 while adjusting so a full second follows release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sec_pre <= '0;
    end else if (state != IDLE) begin
      sec_pre <= '0;
    end else if (sec_pre == SEC_LAST) begin
      sec_pre <= '0;
    end else begin
      sec_pre <= sec_pre + 1'b1;
    end
  end

  // Repeat prescaler: free-running, terminal count is the repeat enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_pre <= '0;
    end else if (rep_pre == REP_LAST) begin
      rep_pre <= '0;
    end else begin
      rep_pre <= rep_pre + 1'b1;
    end
  end

  // Repeat engine: count rep_en periods between pulses, shrink the wait per pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      comp  <= COMP_INIT;
    end else if (release_edge) begin
      count <= '0;
      comp  <= COMP_INIT;
    end else if (rep_en) begin
      if (btn) begin
        if (count == comp) begin
          count <= '0;
        end else begin
          count <= count + 1'b1;
        end
        if ((count == '0) && (comp > COMP_FLOOR)) begin
          comp <= comp - COMP_STEP;
        end
      end else begin
        count <= '0;
        comp  <= COMP_INIT;
      end
    end
  end

  // Time digits and the second strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hrs_d    <= 2'd0;
      hrs_u    <= 4'd0;
      min_d    <= 3'd0;
      min_u    <= 4'd0;
      sec_d    <= 3'd0;
      sec_u    <= 4'd0;
      sec_tick <= 1'b0;
    end else begin
      hrs_d    <= hrs_d_n;
      hrs_u    <= hrs_u_n;
      min_d    <= min_d_n;
      min_u    <= min_u_n;
      sec_d    <= sec_d_n;
      sec_u    <= sec_u_n;
      sec_tick <= tick;
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed scenarios plus random button bursts, all
// checked every cycle against a time-in-seconds reference model.
module tb_time_set_ctrl;

  localparam int CLK_HZ    = 20;
  localparam int REPEAT_HZ = 10;
  localparam int RP        = CLK_HZ / REPEAT_HZ;
  localparam int MAX_COUNT = 8;
  localparam int DEC_COUNT = 2;
  localparam int MIN_COUNT = 1;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic adj_hrs = 1'b0;
  logic adj_min = 1'b0;
  logic adj_sec = 1'b0;

  logic [1:0] hrs_d;
  logic [3:0] hrs_u;
  logic [2:0] min_d;
  logic [3:0] min_u;
  logic [2:0] sec_d;
  logic [3:0] sec_u;
  logic       sec_tick;
  logic       adj_active;

  always #5 clk = ~clk;

  time_set_ctrl #(
    .CLK_HZ(CLK_HZ), .REPEAT_HZ(REPEAT_HZ),
    .MAX_COUNT(MAX_COUNT), .DEC_COUNT(DEC_COUNT), .MIN_COUNT(MIN_COUNT)
  ) dut (
    .clk(clk), .reset(reset),
    .adj_hrs(adj_hrs), .adj_min(adj_min), .adj_sec(adj_sec),
    .hrs_d(hrs_d), .hrs_u(hrs_u), .min_d(min_d), .min_u(min_u),
    .sec_d(sec_d), .sec_u(sec_u), .sec_tick(sec_tick), .adj_active(adj_active)
  );

  logic [21:0] obs_vec;
  assign obs_vec = {hrs_d, hrs_u, min_d, min_u, sec_d, sec_u, sec_tick, adj_active};

  int checks = 0;
  int errors = 0;

  // reference model: time as seconds of day, grant as 0 none / 1 h / 2 m / 3 s
  int m_time, m_grant, m_secpre, m_cyc, m_idx, m_next, m_wait;
  bit m_tick, m_active;

  // scoreboard of expected minute values during the auto-repeat run
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_time = 0; m_grant = 0; m_secpre = 0; m_cyc = 0;
    m_idx = 0; m_next = 0; m_wait = MAX_COUNT - 1;
    m_tick = 0; m_active = 0;
  endtask

  // One clock edge of the model with the button levels seen at that edge.
  task automatic model_edge(input logic h, input logic mb, input logic s);
    bit held, rep_en, tick, pulse;
    int g_n, hh, mm, ss;
    held   = (m_grant == 1 && h) || (m_grant == 2 && mb) || (m_grant == 3 && s);
    rep_en = (m_cyc % RP) == RP - 1;
    tick   = (m_grant == 0) && (m_secpre == CLK_HZ - 1);
    pulse  = rep_en && held && (m_idx == m_next);
    if (tick) m_time = (m_time + 1) % 86400;
    hh = m_time / 3600; mm = (m_time / 60) % 60; ss = m_time % 60;
    if (pulse) begin
      case (m_grant)
        1: hh = (hh + 1) % 24;
        2: mm = (mm + 1) % 60;
        3: ss = (ss + 1) % 60;
        default: ;
      endcase
      m_time = hh * 3600 + mm * 60 + ss;
    end
    if (!held) begin
      m_idx = 0; m_next = 0; m_wait = MAX_COUNT - 1;
    end else if (rep_en) begin
      if (pulse) begin
        if (m_wait > MIN_COUNT + DEC_COUNT) m_wait -= DEC_COUNT;
        m_next = m_idx + m_wait + 1;
      end
      m_idx++;
    end
    m_secpre = (m_grant != 0) ? 0 : (m_secpre + 1) % CLK_HZ;
    if (m_grant == 0) g_n = h ? 1 : mb ? 2 : s ? 3 : 0;
    else g_n = held ? m_grant : 0;
    m_tick = tick; m_active = (g_n != 0); m_grant = g_n; m_cyc++;
  endtask

  function automatic logic [21:0] exp_vec();
    int hh, mm, ss;
    hh = m_time / 3600; mm = (m_time / 60) % 60; ss = m_time % 60;
    return {2'(hh / 10), 4'(hh % 10), 3'(mm / 10), 4'(mm % 10),
            3'(ss / 10), 4'(ss % 10), m_tick, m_active};
  endfunction

  function automatic int model_field(input int f);
    if (f == 0) return m_time / 3600;
    if (f == 1) return (m_time / 60) % 60;
    return m_time % 60;
  endfunction

  function automatic int dut_field(input int f);
    if (f == 0) return int'(hrs_d) * 10 + int'(hrs_u);
    if (f == 1) return int'(min_d) * 10 + int'(min_u);
    return int'(sec_d) * 10 + int'(sec_u);
  endfunction

  // driver: apply buttons at negedge, advance model at posedge, compare at next negedge
  task automatic step(input logic h, input logic mb, input logic s);
    adj_hrs = h; adj_min = mb; adj_sec = s;
    @(posedge clk);
    model_edge(h, mb, s);
    @(negedge clk);
    check("cycle", 32'(obs_vec), 32'(exp_vec()));
  endtask

  task automatic hold_until(input logic h, input logic mb, input logic s,
                            input int field, input int target, input string tag);
    for (int i = 0; i < 3000 && model_field(field) != target; i++) step(h, mb, s);
    check(tag, dut_field(field), target);
  endtask

  initial begin
    int ticks, last_tick, first_tick, n_chg, prev_min, saved, saw23;
    int chg_at[$];

    // reset state
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_state", 32'(obs_vec), 32'd0);
    reset = 1'b0;

    // 60 seconds of free running: tick every CLK_HZ cycles, ends at 00:01:00
    ticks = 0; last_tick = 0; first_tick = -1;
    for (int i = 1; i <= 60 * CLK_HZ; i++) begin
      step(0, 0, 0);
      if (sec_tick === 1'b1) begin
        if (first_tick < 0) first_tick = i;
        else check("tick_gap", i - last_tick, CLK_HZ);
        last_tick = i;
        ticks++;
      end
    end
    check("first_tick", first_tick, CLK_HZ);
    check("tick_count", ticks, 60);
    check("time_1min", 32'(obs_vec[21:2]), 32'({2'd0, 4'd0, 3'd0, 4'd1, 3'd0, 4'd0}));

    // preload 23:59:59 through the adjust buttons, then one second wraps to midnight
    hold_until(1, 0, 0, 0, 23, "preset_hrs23");
    step(0, 0, 0);
    hold_until(0, 1, 0, 1, 59, "preset_min59");
    step(0, 0, 0);
    hold_until(0, 0, 1, 2, 59, "preset_sec59");
    step(0, 0, 0);
    ticks = 0;
    for (int i = 0; i < CLK_HZ; i++) begin
      step(0, 0, 0);
      if (sec_tick === 1'b1) ticks++;
    end
    check("midnight_ticks", ticks, 1);
    check("midnight_time", 32'(obs_vec[21:2]), 32'd0);

    // minutes auto-repeat from 58 for 30 repeat periods: 59, 00, 01, ... no hour carry
    hold_until(0, 1, 0, 1, 58, "preset_min58");
    step(0, 0, 0);
    step(0, 1, 0);
    for (int k = 1; k <= 7; k++) exp_q.push_back(8'((58 + k) % 60));
    prev_min = dut_field(1); n_chg = 0;
    for (int i = 1; i <= 30 * RP; i++) begin
      step(0, 1, 0);
      if (dut_field(1) != prev_min) begin
        prev_min = dut_field(1);
        n_chg++;
        chg_at.push_back(i);
        if (exp_q.size() > 0) check("min_seq", prev_min, 32'(exp_q.pop_front()));
        else check("min_extra", n_chg, 7);
      end
    end
    check("min_pulses", n_chg, 7);
    check("min_hours", dut_field(0), 0);
    if (chg_at.size() >= 4) begin
      check("gap_first", chg_at[1] - chg_at[0], 6 * RP);
      check("gap_second", chg_at[2] - chg_at[1], 4 * RP);
      check("gap_steady", chg_at[3] - chg_at[2], 4 * RP);
    end else begin
      check("gap_count", chg_at.size(), 4);
    end
    step(0, 0, 0);

    // seconds held, hours raised later: seconds keep the grant, hours frozen
    saved = model_field(0);
    n_chg = 0; prev_min = dut_field(2);
    for (int i = 0; i < 15; i++) step(0, 0, 1);
    for (int i = 0; i < 15; i++) begin
      step(1, 0, 1);
      if (dut_field(2) != prev_min) begin n_chg++; prev_min = dut_field(2); end
    end
    check("sec_adv_under_hrs", 32'(n_chg > 0), 32'd1);
    check("hrs_frozen", dut_field(0), saved);
    check("adj_s_active", 32'(adj_active), 32'd1);
    step(1, 0, 0);
    check("regrant_idle", 32'(adj_active), 32'd0);
    step(1, 0, 0);
    check("regrant_adj_h", 32'(adj_active), 32'd1);
    for (int i = 0; i < 6 * RP; i++) step(1, 0, 0);
    check("hrs_one_pulse", dut_field(0), (saved + 1) % 24);
    step(0, 0, 0);

    // hours and minutes pressed together at hour 22: hours win and wrap 23 -> 00
    hold_until(1, 0, 0, 0, 22, "preset_hrs22");
    step(0, 0, 0);
    saved = model_field(1); saw23 = 0;
    for (int i = 0; i < 500 && model_field(0) != 0; i++) begin
      step(1, 1, 0);
      if (dut_field(0) == 23) saw23 = 1;
    end
    check("prio_saw23", saw23, 1);
    check("prio_hrs_wrap", dut_field(0), 0);
    check("prio_min_kept", dut_field(1), saved);
    step(0, 0, 0);

    // asynchronous reset in the middle of an hours adjust at 05
    hold_until(1, 0, 0, 0, 5, "preset_hrs05");
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", 32'(obs_vec), 32'd0);
    model_reset();
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check("held_in_reset", 32'(obs_vec), 32'd0);
    end
    adj_hrs = 1'b0;
    reset = 1'b0;
    first_tick = -1;
    for (int i = 1; i <= CLK_HZ + 2; i++) begin
      step(0, 0, 0);
      if (sec_tick === 1'b1 && first_tick < 0) first_tick = i;
    end
    check("post_reset_tick", first_tick, CLK_HZ);

    // random button bursts against the model
    for (int b = 0; b < 40; b++) begin
      int btns, len;
      btns = $urandom_range(0, 7);
      len  = $urandom_range(1, 25);
      for (int i = 0; i < len; i++) step(btns[2], btns[1], btns[0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Time-of-day controller for the VGA clock: keeps hours/minutes/seconds as BCD digits from a 1 Hz tick derived from the pixel clock. Arbitrates the three adjust buttons onto one shared auto-repeat pulse engine and applies the resulting pulses to the selected field. Sits between the synchronised button inputs and the digit renderer.

## Interface

- CLK_HZ, 31_500_000: system clock frequency; seconds prescaler period.
- REPEAT_HZ, 10: auto-repeat enable rate; repeat prescaler period = CLK_HZ/REPEAT_HZ (integer division).
- MAX_COUNT, 8: initial repeat wait in repeat periods.
- DEC_COUNT, 2: wait decrement per issued pulse.
- MIN_COUNT, 1: wait floor; comparator decrements only while comp > MIN_COUNT+DEC_COUNT.

- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- adj_hrs  in  1  hours-adjust button, synchronised level.
- adj_min  in  1  minutes-adjust button, synchronised level.
- adj_sec  in  1  seconds-adjust button, synchronised level.
- hrs_d  out  2  hours tens, BCD 0-2.
- hrs_u  out  4  hours units, BCD 0-9.
- min_d  out  3  minutes tens, BCD 0-5.
- min_u  out  4  minutes units, BCD 0-9.
- sec_d  out  3  seconds tens, BCD 0-5.
- sec_u  out  4  seconds units, BCD 0-9.
- sec_tick  out  1  one-cycle pulse on each counted second.
- adj_active  out  1  high while arbiter state is not IDLE.

## Operation

- Reset: all digits 0 (00:00:00), state IDLE, both prescalers 0, engine count=0, comp=MAX_COUNT-1, sec_tick=0, adj_active=0.
- Seconds prescaler: counts 0..CLK_HZ-1; tick when count==CLK_HZ-1 and state==IDLE. Held at 0 while state!=IDLE, so time is frozen during adjust; a full second elapses after returning to IDLE.
- Repeat prescaler: free-running 0..CLK_HZ/REPEAT_HZ-1; rep_en high on the terminal count.
- Arbiter states: IDLE, ADJ_H, ADJ_M, ADJ_S. IDLE -> highest-priority held button (hrs > min > sec). ADJ_x -> IDLE when its own button is low, regardless of others. No direct ADJ_x -> ADJ_y; re-grant goes via one IDLE cycle.
- Shared repeat engine, input btn = button of granted state (0 in IDLE). Updates only on rep_en:
  - pulse = rep_en && btn && count==0 (combinational, internal).
  - btn high: count+1; if count==0 and comp > MIN_COUNT+DEC_COUNT then comp-=DEC_COUNT; if count==comp then count=0 (overrides increment).
  - btn low: count=0, comp=MAX_COUNT-1.
  - On ADJ_x -> IDLE, engine is cleared to reset values at that same edge, independent of rep_en.
- Pulse effect (no carry to other fields): ADJ_H: hours +1, 23->00. ADJ_M: minutes +1, 59->00. ADJ_S: seconds +1, 59->00.
- Tick effect: seconds +1; 59->00 carries minutes +1; 59->00 carries hours +1; 23:59:59 -> 00:00:00.
- Digits always hold legal BCD; units wrap 9->0 with tens +1.

## Timing

- All outputs registered; a field updates on the edge where pulse/tick is high and is visible the following cycle.
- sec_tick asserts in the same cycle the seconds digits update.
- Grant: button high in cycle n -> state ADJ_x and adj_active=1 from cycle n+1.
- First increment: on the first rep_en with state granted (0 to CLK_HZ/REPEAT_HZ-1 cycles after grant).
- Default repeat spacing (MAX 8, DEC 2, MIN 1): pulses at rep_en indices 0, 6, 10, 14, ... (gaps 6 then 4 steady).
- Button released: state IDLE next cycle; no pulse is issued after the release edge.
- Tick and adjust never coincide (tick gated by IDLE).
- Reset asserted mid-adjust: immediate clear to reset values; no pulse or tick until released.

## Test plan

- CLK_HZ=20, REPEAT_HZ=10, run 60 ticks from reset -> sec_tick every 20 cycles, time 00:01:00, digits stay legal BCD.
- Preload 23:59:59 via adjust, run one second -> 00:00:00, single sec_tick.
- Hold adj_min 30 rep_en periods at 00:58:xx -> minutes 59, 00, 01..., hours unchanged, pulse spacing 6 then 4 rep_en periods.
- Hold adj_sec, then raise adj_hrs -> state stays ADJ_S and only seconds advance; drop adj_sec -> one IDLE cycle, then ADJ_H.
- Raise adj_hrs and adj_min in the same cycle at hour 22 -> ADJ_H wins; hours 22->23->00; minutes unchanged.
- Assert reset mid-adjust while hours=05 -> outputs 00:00:00, adj_active=0 asynchronously; after release, 20 cycles to first sec_tick.
